// File: rtl/cruise_input_conditioner.sv
// Conditions raw cruise-control switch and pedal levels: synchronize, debounce, gate,
// and turn stalk presses into single-cycle command pulses with accel/coast auto-repeat.
module cruise_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic throttle_raw,
    input  logic brake_raw,
    input  logic set_raw,
    input  logic accel_raw,
    input  logic coast_raw,
    input  logic cancel_raw,
    input  logic resume_raw,
    output logic throttle,
    output logic brake,
    output logic set,
    output logic accel,
    output logic coast,
    output logic cancel,
    output logic resume,
    output logic pedal_conflict
);

    localparam int NUM_IN = 7;
    localparam int THR = 0;
    localparam int BRK = 1;
    localparam int SET = 2;
    localparam int ACC = 3;
    localparam int CST = 4;
    localparam int CAN = 5;
    localparam int RES = 6;

    logic [NUM_IN-1:0]      raw_in, sync_a, sync_b, db, db_next, rise;
    logic [NUM_IN-1:0][7:0] db_cnt, db_cnt_next;

    logic cancel_p, cmd_gate, dir_conflict, set_p, resume_p;

    // Index 0 = accel, index 1 = coast.
    logic [1:0]      rep_db, rep_db_next, rep_active, rep_phase, rep_phase_next, rep_pulse;
    logic [1:0][7:0] rep_cnt, rep_cnt_next;

    assign raw_in = {resume_raw, cancel_raw, coast_raw, accel_raw,
                     set_raw, brake_raw, throttle_raw};

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            db_next[i]     = db[i];
            db_cnt_next[i] = 8'd0;
            if (sync_b[i] != db[i]) begin
                if (db_cnt[i] + 8'd1 == 8'(DEBOUNCE_CYCLES)) begin
                    db_next[i] = sync_b[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Outputs are registered from db_next so they line up with the edge db changes on.
    assign rise         = db_next & ~db;
    assign cancel_p     = rise[CAN];
    assign cmd_gate     = cancel_p | db_next[BRK];
    assign dir_conflict = db_next[ACC] & db_next[CST];
    assign set_p        = rise[SET] & ~cmd_gate;
    assign resume_p     = rise[RES] & ~cmd_gate & ~rise[SET];

    assign rep_db      = {db[CST], db[ACC]};
    assign rep_db_next = {db_next[CST], db_next[ACC]};
    assign rep_active  = rep_db_next & {2{~cmd_gate & ~dir_conflict}};

    // A level held through a gate is not a rise, so it only resumes repeating after REPEAT_DELAY.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rep_cnt_next[k]   = 8'd0;
            rep_phase_next[k] = 1'b0;
            rep_pulse[k]      = 1'b0;
            if (rep_active[k]) begin
                if (!rep_db[k]) begin
                    rep_pulse[k] = 1'b1;
                end else if (rep_cnt[k] + 8'd1 ==
                             (rep_phase[k] ? 8'(REPEAT_PERIOD) : 8'(REPEAT_DELAY))) begin
                    rep_pulse[k]      = 1'b1;
                    rep_phase_next[k] = 1'b1;
                end else begin
                    rep_cnt_next[k]   = rep_cnt[k] + 8'd1;
                    rep_phase_next[k] = rep_phase[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a         <= '0;
            sync_b         <= '0;
            db             <= '0;
            db_cnt         <= '0;
            rep_cnt        <= '0;
            rep_phase      <= '0;
            throttle       <= 1'b0;
            brake          <= 1'b0;
            set            <= 1'b0;
            accel          <= 1'b0;
            coast          <= 1'b0;
            cancel         <= 1'b0;
            resume         <= 1'b0;
            pedal_conflict <= 1'b0;
        end else begin
            sync_a         <= raw_in;
            sync_b         <= sync_a;
            db             <= db_next;
            db_cnt         <= db_cnt_next;
            rep_cnt        <= rep_cnt_next;
            rep_phase      <= rep_phase_next;
            throttle       <= db_next[THR] & ~db_next[BRK];
            brake          <= db_next[BRK];
            set            <= set_p;
            accel          <= rep_pulse[0];
            coast          <= rep_pulse[1];
            cancel         <= cancel_p;
            resume         <= resume_p;
            pedal_conflict <= db_next[THR] & db_next[BRK];
        end
    end

endmodule

// File: tb/tb_cruise_input_conditioner.sv
// Directed bench for cruise_input_conditioner at default parameters; expected output
// vectors {throttle,brake,set,accel,coast,cancel,resume,pedal_conflict} are hand-derived.
module tb_cruise_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic throttle_raw, brake_raw, set_raw, accel_raw, coast_raw, cancel_raw, resume_raw;
    logic throttle, brake, set, accel, coast, cancel, resume, pedal_conflict;
    logic [7:0] obs;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cruise_input_conditioner dut (
        .clk            (clk),
        .reset          (reset),
        .throttle_raw   (throttle_raw),
        .brake_raw      (brake_raw),
        .set_raw        (set_raw),
        .accel_raw      (accel_raw),
        .coast_raw      (coast_raw),
        .cancel_raw     (cancel_raw),
        .resume_raw     (resume_raw),
        .throttle       (throttle),
        .brake          (brake),
        .set            (set),
        .accel          (accel),
        .coast          (coast),
        .cancel         (cancel),
        .resume         (resume),
        .pedal_conflict (pedal_conflict)
    );

    assign obs = {throttle, brake, set, accel, coast, cancel, resume, pedal_conflict};

    // One rising edge, then sample/drive on the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        {throttle_raw, brake_raw, set_raw, accel_raw, coast_raw, cancel_raw, resume_raw} = '0;
        repeat (3) tick;
        chk("reset", 0, 8'b0);
        reset = 1'b0;
        tick;
        chk("idle", 1, 8'b0);

        // Bouncing set, then held: one pulse after edge 6 of the stable level.
        for (int c = 0; c < 10; c++) begin
            set_raw = (c % 2 == 0);
            tick;
            chk("set_bounce", c + 1, 8'b0);
        end
        set_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("set_hold", k, {2'b00, 1'(k == 6), 5'b0});
        end
        set_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("set_release", k, 8'b0);
        end

        // Accel held edges 1..40: pulses at 6, 22, 30, 38; repeat at 46 falls with db.
        accel_raw = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick;
            chk("accel_repeat", k, {3'b000, 1'(k == 6 || k == 22 || k == 30 || k == 38), 4'b0});
            if (k == 40) accel_raw = 1'b0;
        end

        // Brake blocks set, and release of brake does not replay it.
        brake_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("brake_on", k, {1'b0, 1'(k >= 6), 6'b0});
        end
        set_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("set_under_brake", k, 8'b0100_0000);
        end
        brake_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("brake_release", k, {1'b0, 1'(k < 6), 6'b0});
        end
        set_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("set_off", k, 8'b0);
        end

        // Pedal conflict: brake wins, throttle returns once brake is released.
        throttle_raw = 1'b1;
        brake_raw    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("pedals_both", k, {1'b0, 1'(k >= 6), 5'b0, 1'(k >= 6)});
        end
        brake_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("brake_drop", k, {1'(k >= 6), 1'(k < 6), 5'b0, 1'(k < 6)});
        end
        throttle_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("throttle_drop", k, {1'(k < 6), 7'b0});
        end

        // Accel and coast together: nothing for 50 cycles and nothing on release.
        accel_raw = 1'b1;
        coast_raw = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick;
            chk("accel_coast", k, 8'b0);
        end
        accel_raw = 1'b0;
        coast_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("accel_coast_off", k, 8'b0);
        end

        // Set and resume rising together: set only.
        set_raw    = 1'b1;
        resume_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("set_resume", k, {2'b00, 1'(k == 6), 5'b0});
        end
        set_raw    = 1'b0;
        resume_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("set_resume_off", k, 8'b0);
        end

        // Cancel passes brake gating.
        brake_raw = 1'b1;
        repeat (8) tick;
        cancel_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("cancel_brake", k, {2'b01, 3'b000, 1'(k == 6), 2'b00});
        end
        brake_raw  = 1'b0;
        cancel_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("cancel_brake_off", k, {1'b0, 1'(k < 6), 6'b0});
        end

        // Cancel suppresses accel's first pulse; repeat restarts from the gate release.
        accel_raw  = 1'b1;
        cancel_raw = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick;
            chk("cancel_accel", k, {3'b000, 1'(k == 22), 1'b0, 1'(k == 6), 2'b00});
        end
        accel_raw  = 1'b0;
        cancel_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("cancel_accel_off", k, {3'b000, 1'(k == 5), 4'b0});
        end

        // Reset mid-debounce: resume held through reset pulses 6 edges after release.
        resume_raw = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk("resume_pre_reset", k, 8'b0);
        end
        reset = 1'b1;
        tick;
        chk("resume_in_reset", 4, 8'b0);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("resume_after_reset", k, {6'b0, 1'(k == 6), 1'b0});
        end
        resume_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("resume_off", k, 8'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
